// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response and data_memory-side bus of mem_access_unit.
// The unit connects through the slave modport; the MEM stage and the memory use master.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              stall;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, stall, resp_valid, resp_rdata, resp_err,
    input  mem_read, mem_write, mem_adr, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, stall, resp_valid, resp_rdata, resp_err,
    output mem_read, mem_write, mem_adr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store initiator in front of a word-organised data_memory.
// Define MAU_ALIGN_CHECK_EN to reject misaligned or invalid-size requests with resp_err.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_WR,
    S_RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t            state;
  logic              ready_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_adr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
`ifdef MAU_ALIGN_CHECK_EN
  logic              resp_err_q;
`endif

  // Request fields kept for the data phase; only meaningful after acceptance.
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [1:0]        lane_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic [1:0]        size_eff;
  logic [ADDR_W-1:0] word_adr;
`ifdef MAU_ALIGN_CHECK_EN
  logic              misal;
`endif

  // Right-align the addressed lane, then sign- or zero-extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overlay the store lanes of wdata onto the word read back from memory.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  always_comb begin
    accept   = bus.req_valid & ready_q;
    word_adr = {bus.req_addr[ADDR_W-1:2], 2'b00};
`ifdef MAU_ALIGN_CHECK_EN
    size_eff = bus.req_size;
    misal    = (bus.req_size == 2'b11) ||
               ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
               ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
    size_eff = (bus.req_size == 2'b11) ? SZ_WORD : bus.req_size;
`endif
  end

  // Acceptance: capture the request; everything later works from these copies.
  always_ff @(posedge clk) begin
    if (accept) begin
      size_q  <= size_eff;
      sgn_q   <= bus.req_signed;
      lane_q  <= bus.req_addr[1:0];
      wdata_q <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      ready_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_adr_q    <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
`ifdef MAU_ALIGN_CHECK_EN
      resp_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
`ifdef MAU_ALIGN_CHECK_EN
            if (misal) begin
              state        <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else
`endif
            if (!bus.req_write) begin
              state      <= S_RD;
              mem_read_q <= 1'b1;
              mem_adr_q  <= word_adr;
            end else if (size_eff == SZ_WORD) begin
              state       <= S_WR;
              mem_write_q <= 1'b1;
              mem_adr_q   <= word_adr;
              mem_wdata_q <= bus.req_wdata;
            end else begin
              state      <= S_RMW_RD;
              mem_read_q <= 1'b1;
              mem_adr_q  <= word_adr;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        // Load data phase: mem_rdata must be settled by this edge.
        S_RD: begin
          state        <= S_RESP;
          mem_read_q   <= 1'b0;
          mem_adr_q    <= '0;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= load_extract(bus.mem_rdata, size_q, lane_q, sgn_q);
        end
        S_RMW_RD: begin
          state       <= S_WR;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b1;
          mem_wdata_q <= store_merge(bus.mem_rdata, wdata_q, size_q, lane_q);
        end
        S_WR: begin
          state        <= S_RESP;
          mem_write_q  <= 1'b0;
          mem_adr_q    <= '0;
          mem_wdata_q  <= '0;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= '0;
        end
        S_RESP: begin
          state        <= S_IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
`ifdef MAU_ALIGN_CHECK_EN
          resp_err_q   <= 1'b0;
`endif
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.stall      = bus.req_valid & ~ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_adr    = mem_adr_q;
  assign bus.mem_wdata  = mem_wdata_q;
`ifdef MAU_ALIGN_CHECK_EN
  assign bus.resp_err   = resp_err_q;
`else
  assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small combinational-read word memory
// covering 0x2000-0x203C.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] mem [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  assign bus.mem_rdata = mem[bus.mem_adr[5:2]];

  always @(posedge clk) begin
    if (pl_en)              mem[pl_idx] <= pl_data;
    else if (bus.mem_write) mem[bus.mem_adr[5:2]] <= bus.mem_wdata;
  end

  int n_chk = 0;
  int n_err = 0;

  // observations from the last operation
  int          lat, nrd, nwr, nstall, acc_wait;
  logic [31:0] o_rdata, o_radr, o_wadr, o_wdata;
  logic        o_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Present a request, wait for acceptance, then scramble the inputs.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd);
    acc_wait = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = ad; bus.req_wdata = wd;
    while (!bus.req_ready && acc_wait < 20) begin
      @(negedge clk);
      acc_wait++;
    end
    if (acc_wait >= 20) check("accept_timeout", 32'(acc_wait), 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.req_write = ~wr; bus.req_size = ~sz;
    bus.req_signed = ~sg; bus.req_addr = 32'hFFFF_FFFD; bus.req_wdata = 32'h0BAD_0BAD;
  endtask

  task automatic collect();
    lat = 0; nrd = 0; nwr = 0; nstall = 0;
    o_rdata = '0; o_radr = '0; o_wadr = '0; o_wdata = '0; o_err = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus.mem_read)  begin nrd++; o_radr = bus.mem_adr; end
      if (bus.mem_write) begin nwr++; o_wadr = bus.mem_adr; o_wdata = bus.mem_wdata; end
      if (bus.stall) nstall++;
      if (bus.resp_valid) begin
        lat = n; o_rdata = bus.resp_rdata; o_err = bus.resp_err;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] ad, input logic [31:0] wd,
                        input int e_lat, input int e_rd, input int e_wr,
                        input logic [31:0] e_rdata, input logic e_err,
                        input logic [31:0] e_adr, input logic [31:0] e_wd);
    issue(wr, sz, sg, ad, wd);
    collect();
    check({tag, "_lat"},   32'(lat),   32'(e_lat));
    check({tag, "_rdata"}, o_rdata,    e_rdata);
    check({tag, "_err"},   32'(o_err), 32'(e_err));
    check({tag, "_nrd"},   32'(nrd),   32'(e_rd));
    check({tag, "_nwr"},   32'(nwr),   32'(e_wr));
    if (e_rd != 0) check({tag, "_radr"}, o_radr, e_adr);
    if (e_wr != 0) begin
      check({tag, "_wadr"},  o_wadr,  e_adr);
      check({tag, "_wdata"}, o_wdata, e_wd);
    end
    @(negedge clk);
    check({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    // reset state
    check("rst_ready",      32'(bus.req_ready),  32'd0);
    check("rst_stall",      32'(bus.stall),      32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err",   32'(bus.resp_err),   32'd0);
    check("rst_resp_rdata", bus.resp_rdata,      32'd0);
    check("rst_mem_read",   32'(bus.mem_read),   32'd0);
    check("rst_mem_write",  32'(bus.mem_write),  32'd0);
    check("rst_mem_adr",    bus.mem_adr,         32'd0);
    check("rst_mem_wdata",  bus.mem_wdata,       32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.req_ready), 32'd1);

    preload(4'd0, 32'hCAFE_F00D);
    preload(4'd1, 32'h8899_AABB);
    preload(4'd2, 32'h0000_0000);

    //     tag          wr    sz     sg    addr          wdata          lat rd wr rdata          err   adr           wdata
    run_op("lb_2005",  1'b0, 2'b00, 1'b1, 32'h0000_2005, 32'h0,        2, 1, 0, 32'hFFFF_FFAA, 1'b0, 32'h0000_2004, 32'h0);
    run_op("lbu_2007", 1'b0, 2'b00, 1'b0, 32'h0000_2007, 32'h0,        2, 1, 0, 32'h0000_0088, 1'b0, 32'h0000_2004, 32'h0);
    run_op("lh_2006",  1'b0, 2'b01, 1'b1, 32'h0000_2006, 32'h0,        2, 1, 0, 32'hFFFF_8899, 1'b0, 32'h0000_2004, 32'h0);
    run_op("lhu_2004", 1'b0, 2'b01, 1'b0, 32'h0000_2004, 32'h0,        2, 1, 0, 32'h0000_AABB, 1'b0, 32'h0000_2004, 32'h0);
    run_op("lb_2004",  1'b0, 2'b00, 1'b1, 32'h0000_2004, 32'h0,        2, 1, 0, 32'hFFFF_FFBB, 1'b0, 32'h0000_2004, 32'h0);
    run_op("lbu_2006", 1'b0, 2'b00, 1'b0, 32'h0000_2006, 32'h0,        2, 1, 0, 32'h0000_0099, 1'b0, 32'h0000_2004, 32'h0);
    run_op("sh_2006",  1'b1, 2'b01, 1'b0, 32'h0000_2006, 32'h0000_1234, 3, 1, 1, 32'h0,        1'b0, 32'h0000_2004, 32'h1234_AABB);
    run_op("lw_2004",  1'b0, 2'b10, 1'b1, 32'h0000_2004, 32'h0,        2, 1, 0, 32'h1234_AABB, 1'b0, 32'h0000_2004, 32'h0);
    run_op("sb_2005",  1'b1, 2'b00, 1'b0, 32'h0000_2005, 32'hFFFF_FF5A, 3, 1, 1, 32'h0,        1'b0, 32'h0000_2004, 32'h1234_5ABB);
`ifdef MAU_ALIGN_CHECK_EN
    run_op("lw_2002",  1'b0, 2'b10, 1'b0, 32'h0000_2002, 32'h0,        1, 0, 0, 32'h0,        1'b1, 32'h0,        32'h0);
    run_op("lsz3",     1'b0, 2'b11, 1'b0, 32'h0000_2004, 32'h0,        1, 0, 0, 32'h0,        1'b1, 32'h0,        32'h0);
    run_op("lh_2005",  1'b0, 2'b01, 1'b1, 32'h0000_2005, 32'h0,        1, 0, 0, 32'h0,        1'b1, 32'h0,        32'h0);
    run_op("sh_2005",  1'b1, 2'b01, 1'b0, 32'h0000_2005, 32'h0000_7777, 1, 0, 0, 32'h0,       1'b1, 32'h0,        32'h0);
`else
    run_op("lw_2002",  1'b0, 2'b10, 1'b0, 32'h0000_2002, 32'h0,        2, 1, 0, 32'hCAFE_F00D, 1'b0, 32'h0000_2000, 32'h0);
    run_op("lsz3",     1'b0, 2'b11, 1'b0, 32'h0000_2004, 32'h0,        2, 1, 0, 32'h1234_5ABB, 1'b0, 32'h0000_2004, 32'h0);
    run_op("lh_2005",  1'b0, 2'b01, 1'b1, 32'h0000_2005, 32'h0,        2, 1, 0, 32'h0000_5ABB, 1'b0, 32'h0000_2004, 32'h0);
`endif

    // reset asserted during RMW_RD of a byte store
    issue(1'b1, 2'b00, 1'b0, 32'h0000_2004, 32'h0000_0077);
    @(negedge clk);
    check("abort_in_rmw_rd", 32'(bus.mem_read), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_mem_read",   32'(bus.mem_read),   32'd0);
    check("abort_mem_write",  32'(bus.mem_write),  32'd0);
    check("abort_mem_adr",    bus.mem_adr,         32'd0);
    check("abort_mem_wdata",  bus.mem_wdata,       32'd0);
    check("abort_ready",      32'(bus.req_ready),  32'd0);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    nwr = 0; nrd = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.mem_write) nwr++;
      if (bus.resp_valid) nrd++;
    end
    rst = 1'b1;
    @(negedge clk);
    if (bus.mem_write) nwr++;
    if (bus.resp_valid) nrd++;
    check("abort_ready_after", 32'(bus.req_ready), 32'd1);
    check("abort_no_write",    32'(nwr),           32'd0);
    check("abort_no_resp",     32'(nrd),           32'd0);
    check("abort_word_kept",   mem[1],             32'h1234_5ABB);

    // word store with a load held valid behind it
    issue(1'b1, 2'b10, 1'b0, 32'h0000_2008, 32'hDEAD_BEEF);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0000_2008; bus.req_wdata = '0;
    collect();
    check("sw_lat",     32'(lat),    32'd2);
    check("sw_nrd",     32'(nrd),    32'd0);
    check("sw_nwr",     32'(nwr),    32'd1);
    check("sw_wdata",   o_wdata,     32'hDEAD_BEEF);
    check("sw_wadr",    o_wadr,      32'h0000_2008);
    check("sw_stall",   32'(nstall), 32'd2);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_2008, 32'h0);
    check("held_accept_wait", 32'(acc_wait), 32'd0);
    collect();
    check("held_lat",   32'(lat),    32'd2);
    check("held_rdata", o_rdata,     32'hDEAD_BEEF);
    check("held_radr",  o_radr,      32'h0000_2008);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
